axil_wr_protocol_checker: RTL and testbench

//  Synthesizable AXI4-Lite write-path protocol checker covering the AW, W and B channels.

---
 rtl/axil_chk_pkg.sv | 38 +++
 rtl/axil_stall_timer.sv | 42 ++++
 rtl/axil_wr_protocol_checker.sv | 169 ++++++++++++++++
 tb/tb_axil_wr_protocol_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_chk_pkg.sv
// Shared definitions for the AXI4-Lite write-path protocol checker:
// check IDs, response encoding and a lowest-set-bit helper.
package axil_chk_pkg;

  localparam int NUM_CHECKS = 12;
  localparam int CHK_ID_W   = 4;

  typedef enum logic [CHK_ID_W-1:0] {
    CHK_AW_VALID_DROP     = 4'd0,
    CHK_AW_PAYLOAD_CHG    = 4'd1,
    CHK_W_VALID_DROP      = 4'd2,
    CHK_W_PAYLOAD_CHG     = 4'd3,
    CHK_B_VALID_DROP      = 4'd4,
    CHK_B_RESP_CHG        = 4'd5,
    CHK_AW_TIMEOUT        = 4'd6,
    CHK_W_TIMEOUT         = 4'd7,
    CHK_B_TIMEOUT         = 4'd8,
    CHK_B_UNEXPECTED      = 4'd9,
    CHK_OUTSTANDING_OVF   = 4'd10,
    CHK_VALID_AFTER_RESET = 4'd11
  } chk_id_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // Lowest-numbered asserted check wins when several fire together.
  function automatic logic [CHK_ID_W-1:0] lowest_id(input logic [NUM_CHECKS-1:0] v);
    lowest_id = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (v[i]) lowest_id = CHK_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/axil_stall_timer.sv
// Counts consecutive valid&!ready cycles and pulses once on the MAXWAIT-th one.
// The count restarts whenever the stall condition goes away.
module axil_stall_timer #(
  parameter int MAXWAIT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  input  logic en,
  output logic timeout_pulse
);

  generate
    if (MAXWAIT == 0) begin : g_off
      assign timeout_pulse = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(MAXWAIT + 1);
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          stall;

      assign stall = en & valid & ~ready;

      // Saturate at MAXWAIT so the pulse cannot re-fire during one long stall.
      always_comb begin
        cnt_next = '0;
        if (stall) begin
          cnt_next = (cnt_reg == CW'(MAXWAIT)) ? cnt_reg : cnt_reg + CW'(1);
        end
      end

      assign timeout_pulse = stall & (cnt_reg == CW'(MAXWAIT - 1));

      always_ff @(posedge clk) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
      end
    end
  endgenerate

endmodule

// File: rtl/axil_wr_protocol_checker.sv
// Passive AXI4-Lite write-path (AW/W/B) protocol checker with sticky flags,
// error pulse, saturating count and first-error capture.
module axil_wr_protocol_checker
  import axil_chk_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int MAXWAIT          = 5,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int ERR_CNT_W        = 8
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [2:0]                    AXI_AWPROT,
  input  logic                          AXI_AWVALID,
  input  logic                          AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                          AXI_WVALID,
  input  logic                          AXI_WREADY,
  input  logic [1:0]                    AXI_BRESP,
  input  logic                          AXI_BVALID,
  input  logic                          AXI_BREADY,
  input  logic                          err_clr,
  output logic [NUM_CHECKS-1:0]         err_vec,
  output logic                          err_pulse,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [CHK_ID_W-1:0]           first_err_id,
  output logic                          first_err_valid
);

  localparam int PW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_OUTSTANDING);

  logic aw_hs, w_hs, b_hs;
  logic aw_stall_prev, w_stall_prev, b_stall_prev;
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_prev;
  logic [2:0]                    awprot_prev;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_prev;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_prev;
  axi_resp_t                     bresp_prev;
  logic rst_seen;
  logic [1:0] chan_hs, pend_nz, ovf;
  logic [PW-1:0] aw_pend, w_pend;
  logic pend_both;
  logic aw_to, w_to, b_to;
  logic [NUM_CHECKS-1:0] viol;
  logic any_viol;

  assign aw_hs     = AXI_AWVALID & AXI_AWREADY;
  assign w_hs      = AXI_WVALID & AXI_WREADY;
  assign b_hs      = AXI_BVALID & AXI_BREADY;
  assign chan_hs   = {w_hs, aw_hs};
  assign pend_both = &pend_nz;

  // Index 0 tracks AW beats, index 1 tracks W beats; both retire on a B handshake.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pend
      logic [PW-1:0] pend_reg, pend_next;
      logic          dec;

      assign dec         = b_hs & (pend_reg != '0);
      assign ovf[gi]     = chan_hs[gi] & ~dec & (pend_reg == PEND_MAX);
      assign pend_nz[gi] = (pend_reg != '0);

      always_comb begin
        pend_next = pend_reg;
        if (chan_hs[gi] && !dec && !ovf[gi]) pend_next = pend_reg + PW'(1);
        else if (dec && !chan_hs[gi])        pend_next = pend_reg - PW'(1);
      end

      always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) pend_reg <= '0;
        else              pend_reg <= pend_next;
      end
    end
  endgenerate

  assign aw_pend = g_pend[0].pend_reg;
  assign w_pend  = g_pend[1].pend_reg;

  axil_stall_timer #(.MAXWAIT(MAXWAIT)) u_aw_timer (
    .clk(AXI_ACLK), .rst_n(AXI_ARESETN), .valid(AXI_AWVALID), .ready(AXI_AWREADY),
    .en(AXI_ARESETN), .timeout_pulse(aw_to)
  );
  axil_stall_timer #(.MAXWAIT(MAXWAIT)) u_w_timer (
    .clk(AXI_ACLK), .rst_n(AXI_ARESETN), .valid(AXI_WVALID), .ready(AXI_WREADY),
    .en(AXI_ARESETN), .timeout_pulse(w_to)
  );
  // Here "stalled" means a response is owed but BVALID has not appeared yet.
  axil_stall_timer #(.MAXWAIT(MAXWAIT)) u_b_timer (
    .clk(AXI_ACLK), .rst_n(AXI_ARESETN), .valid(pend_both), .ready(AXI_BVALID),
    .en(AXI_ARESETN), .timeout_pulse(b_to)
  );

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      aw_stall_prev <= 1'b0;
      w_stall_prev  <= 1'b0;
      b_stall_prev  <= 1'b0;
      awaddr_prev   <= '0;
      awprot_prev   <= '0;
      wdata_prev    <= '0;
      wstrb_prev    <= '0;
      bresp_prev    <= RESP_OKAY;
      rst_seen      <= 1'b0;
    end else begin
      aw_stall_prev <= AXI_AWVALID & ~AXI_AWREADY;
      w_stall_prev  <= AXI_WVALID & ~AXI_WREADY;
      b_stall_prev  <= AXI_BVALID & ~AXI_BREADY;
      awaddr_prev   <= AXI_AWADDR;
      awprot_prev   <= AXI_AWPROT;
      wdata_prev    <= AXI_WDATA;
      wstrb_prev    <= AXI_WSTRB;
      bresp_prev    <= axi_resp_t'(AXI_BRESP);
      rst_seen      <= 1'b1;
    end
  end

  always_comb begin
    viol = '0;
    viol[CHK_AW_VALID_DROP]     = aw_stall_prev & ~AXI_AWVALID;
    viol[CHK_AW_PAYLOAD_CHG]    = aw_stall_prev & AXI_AWVALID &
                                  ({AXI_AWADDR, AXI_AWPROT} != {awaddr_prev, awprot_prev});
    viol[CHK_W_VALID_DROP]      = w_stall_prev & ~AXI_WVALID;
    viol[CHK_W_PAYLOAD_CHG]     = w_stall_prev & AXI_WVALID &
                                  ({AXI_WDATA, AXI_WSTRB} != {wdata_prev, wstrb_prev});
    viol[CHK_B_VALID_DROP]      = b_stall_prev & ~AXI_BVALID;
    viol[CHK_B_RESP_CHG]        = b_stall_prev & AXI_BVALID & (AXI_BRESP != bresp_prev);
    viol[CHK_AW_TIMEOUT]        = aw_to;
    viol[CHK_W_TIMEOUT]         = w_to;
    viol[CHK_B_TIMEOUT]         = b_to;
    viol[CHK_B_UNEXPECTED]      = b_hs & ~pend_both;
    viol[CHK_OUTSTANDING_OVF]   = |ovf;
    viol[CHK_VALID_AFTER_RESET] = ~rst_seen & (AXI_AWVALID | AXI_WVALID | AXI_BVALID);
    if (!AXI_ARESETN) viol = '0;
  end

  assign any_viol = |viol;

  // A clear coinciding with a violation restarts the record from that violation.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      err_vec         <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      first_err_id    <= '0;
      first_err_valid <= 1'b0;
    end else begin
      err_pulse <= any_viol;
      if (err_clr) begin
        err_vec         <= viol;
        err_count       <= any_viol ? ERR_CNT_W'(1) : '0;
        first_err_valid <= any_viol;
        first_err_id    <= any_viol ? lowest_id(viol) : '0;
      end else begin
        err_vec <= err_vec | viol;
        if (any_viol && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
        if (any_viol && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_id    <= lowest_id(viol);
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_wr_protocol_checker.sv
// Directed bench for axil_wr_protocol_checker: stimulus pushes expected error
// records; a monitor pops and compares one record per err_pulse.
module tb_axil_wr_protocol_checker;

  logic        AXI_ACLK = 1'b0;
  logic        AXI_ARESETN;
  logic [7:0]  AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID, AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID, AXI_BREADY;
  logic        err_clr;
  logic [11:0] err_vec;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [3:0]  first_err_id;
  logic        first_err_valid;

  typedef struct packed {
    logic [11:0] vec;
    logic [7:0]  cnt;
    logic [3:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 AXI_ACLK = ~AXI_ACLK;

  axil_wr_protocol_checker #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8), .MAXWAIT(5),
    .MAX_OUTSTANDING(2), .ERR_CNT_W(8)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .err_clr(err_clr), .err_vec(err_vec), .err_pulse(err_pulse),
    .err_count(err_count), .first_err_id(first_err_id),
    .first_err_valid(first_err_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic push(input logic [11:0] vec, input logic [7:0] cnt, input logic [3:0] id);
    exp_t e;
    e.vec = vec;
    e.cnt = cnt;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    AXI_ARESETN = 1'b0;
    AXI_AWADDR = 8'h00; AXI_AWPROT = 3'd0; AXI_AWVALID = 1'b0; AXI_AWREADY = 1'b0;
    AXI_WDATA = 32'h0; AXI_WSTRB = 4'hf; AXI_WVALID = 1'b0; AXI_WREADY = 1'b0;
    AXI_BRESP = 2'b00; AXI_BVALID = 1'b0; AXI_BREADY = 1'b0;
    err_clr = 1'b0;
    step();
    step();
  endtask

  task automatic release_idle();
    AXI_ARESETN = 1'b1;
    step();
  endtask

  // One record per err_pulse cycle: sticky vector, count and first ID after that event.
  always @(negedge AXI_ACLK) begin
    if (AXI_ARESETN && err_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got vec=0x%03h expected no pulse", err_vec);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pulse: vec=0x%03h count=%0d id=%0d valid=%0d", err_vec, err_count,
                 first_err_id, first_err_valid);
        chk("mon_err_vec", 32'(err_vec), 32'(e.vec));
        chk("mon_err_count", 32'(err_count), 32'(e.cnt));
        chk("mon_first_id", 32'(first_err_id), 32'(e.id));
        chk("mon_first_valid", 32'(first_err_valid), 32'd1);
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_err_vec", 32'(err_vec), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'h0);
    chk("rst_first_valid", 32'(first_err_valid), 32'h0);

    // 1: AWVALID in first cycle after reset release (handshakes, leaving aw_pend=1)
    push(12'h800, 8'd1, 4'd11);
    AXI_ARESETN = 1'b1; AXI_AWVALID = 1'b1; AXI_AWREADY = 1'b1; AXI_AWADDR = 8'h10;
    step();
    chk("t1_err_vec", 32'(err_vec), 32'h800);
    chk("t1_first_id", 32'(first_err_id), 32'd11);
    AXI_AWVALID = 1'b0; AXI_AWREADY = 1'b0;
    step();
    chk("t1_aw_pend", 32'(dut.aw_pend), 32'd1);

    // 2: WDATA changes under stall; reset first discards the pending AW
    do_reset();
    chk("t2_aw_pend_after_rst", 32'(dut.aw_pend), 32'd0);
    release_idle();
    AXI_WVALID = 1'b1; AXI_WREADY = 1'b0; AXI_WDATA = 32'h1234;
    step();
    push(12'h008, 8'd1, 4'd3);
    AXI_WDATA = 32'h5678;
    step();
    chk("t2_pulse_on", 32'(err_pulse), 32'd1);
    chk("t2_err_vec", 32'(err_vec), 32'h008);
    AXI_WREADY = 1'b1;
    step();
    chk("t2_pulse_off", 32'(err_pulse), 32'd0);
    AXI_WVALID = 1'b0; AXI_WREADY = 1'b0;
    step();

    // 3: AW stalled for 10 cycles, timeout on stall cycle 5 only
    do_reset();
    release_idle();
    push(12'h040, 8'd1, 4'd6);
    AXI_AWVALID = 1'b1; AXI_AWREADY = 1'b0; AXI_AWADDR = 8'h40;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t3_aw_timeout_c%0d", i), 32'(err_vec[6]), (i >= 5) ? 32'd1 : 32'd0);
    end
    chk("t3_err_count", 32'(err_count), 32'd1);
    AXI_AWREADY = 1'b1;
    step();
    AXI_AWVALID = 1'b0; AXI_AWREADY = 1'b0;
    step();

    // 4: B handshake with nothing outstanding
    do_reset();
    release_idle();
    push(12'h200, 8'd1, 4'd9);
    AXI_BVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    AXI_BVALID = 1'b0; AXI_BREADY = 1'b0;
    step();
    chk("t4_err_vec", 32'(err_vec), 32'h200);
    chk("t4_aw_pend", 32'(dut.aw_pend), 32'd0);
    chk("t4_w_pend", 32'(dut.w_pend), 32'd0);

    // 5: third AW+W beat overflows MAX_OUTSTANDING=2, then two B beats drain
    do_reset();
    release_idle();
    AXI_AWVALID = 1'b1; AXI_AWREADY = 1'b1; AXI_WVALID = 1'b1; AXI_WREADY = 1'b1;
    step();
    step();
    chk("t5_no_err_yet", 32'(err_vec), 32'h0);
    push(12'h400, 8'd1, 4'd10);
    step();
    chk("t5_ovf", 32'(err_vec), 32'h400);
    AXI_AWVALID = 1'b0; AXI_AWREADY = 1'b0; AXI_WVALID = 1'b0; AXI_WREADY = 1'b0;
    AXI_BVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    step();
    AXI_BVALID = 1'b0; AXI_BREADY = 1'b0;
    step();
    chk("t5_aw_pend", 32'(dut.aw_pend), 32'd0);
    chk("t5_w_pend", 32'(dut.w_pend), 32'd0);
    chk("t5_err_count", 32'(err_count), 32'd1);

    // 6: err_clr coincides with a W valid drop under stall
    do_reset();
    release_idle();
    push(12'h200, 8'd1, 4'd9);
    AXI_BVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    AXI_BVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_WVALID = 1'b1; AXI_WREADY = 1'b0; AXI_WDATA = 32'hcafe;
    step();
    push(12'h004, 8'd1, 4'd2);
    AXI_WVALID = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t6_err_vec", 32'(err_vec), 32'h004);
    chk("t6_err_count", 32'(err_count), 32'd1);
    chk("t6_first_id", 32'(first_err_id), 32'd2);
    step();

    // 7: AW and W drop together (lowest ID wins), then a plain clear
    do_reset();
    release_idle();
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1;
    step();
    push(12'h005, 8'd1, 4'd0);
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    step();
    chk("t7_err_vec", 32'(err_vec), 32'h005);
    chk("t7_first_id", 32'(first_err_id), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t7_clr_vec", 32'(err_vec), 32'h0);
    chk("t7_clr_count", 32'(err_count), 32'd0);
    chk("t7_clr_valid", 32'(first_err_valid), 32'd0);

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
